// File: rtl/mux_scanner.sv
// One-hot LED column mux scanner with enforced all-off dead time between selections.
// state | meaning: IDLE lines off, waiting for mode | DEAD all-off dead time toward mux_idx | ON line mux_idx driven
module mux_scanner #(
    parameter int NB_MUX   = 8,
    parameter int DEADTIME = 4,
    localparam int IDX_W   = $clog2(NB_MUX)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [NB_MUX-1:0] manual_sel,
    input  logic              column_ready,
    input  logic              position_sync,
    output logic [NB_MUX-1:0] mux_out,
    output logic [IDX_W-1:0]  mux_idx,
    output logic              mux_ready,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] MODE_MAN  = 2'b10;
    localparam int         CNT_W     = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEADTIME - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_MUX - 1);
    localparam logic [NB_MUX-1:0] SEL_ONE = {{(NB_MUX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DEAD, ON} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              manual_q, manual_d;
    logic              sync_q, sync_d;
    logic [NB_MUX-1:0] mux_out_q, mux_out_d;
    logic              mux_ready_q, mux_ready_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;

    logic              sel_onehot;
    logic [IDX_W-1:0]  sel_pos;
    logic              sync_rise;
    logic              run_ok;

    always_comb begin
        sel_onehot = (manual_sel != '0) && ((manual_sel & (manual_sel - SEL_ONE)) == '0);
        sel_pos    = '0;
        for (int i = 0; i < NB_MUX; i++) begin
            if (manual_sel[i]) sel_pos = IDX_W'(i);
        end
    end

    assign sync_rise = position_sync && !sync_q;
    // A run stays valid only while the mode it was started in is still selected.
    assign run_ok    = enable && (manual_q ? (mode == MODE_MAN) : (mode == MODE_AUTO));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        manual_d     = manual_q;
        sync_d       = position_sync;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (enable && mode == MODE_AUTO) begin
                    state_d  = DEAD;
                    idx_d    = '0;
                    cnt_d    = CNT_LOAD;
                    manual_d = 1'b0;
                end else if (enable && mode == MODE_MAN && sel_onehot) begin
                    state_d  = DEAD;
                    idx_d    = sel_pos;
                    cnt_d    = CNT_LOAD;
                    manual_d = 1'b1;
                end
            end
            DEAD, ON: begin
                if (!run_ok) begin
                    state_d = IDLE;
                end else if (manual_q) begin
                    if (!sel_onehot) begin
                        state_d = IDLE;
                    end else if (sel_pos != idx_q) begin
                        state_d = DEAD;
                        idx_d   = sel_pos;
                        cnt_d   = CNT_LOAD;
                    end else if (state_q == DEAD) begin
                        if (cnt_q == '0) state_d = ON;
                        else             cnt_d   = cnt_q - 1'b1;
                    end
                end else if (sync_rise) begin
                    state_d = DEAD;
                    idx_d   = '0;
                    cnt_d   = CNT_LOAD;
                end else if (state_q == ON && column_ready) begin
                    state_d      = DEAD;
                    cnt_d        = CNT_LOAD;
                    idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    frame_done_d = (idx_q == IDX_LAST);
                end else if (state_q == DEAD) begin
                    if (cnt_q == '0) state_d = ON;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A sync restart swallows a coincident column_ready without flagging it.
        if (!enable) begin
            overrun_d = 1'b0;
        end else if (mode == MODE_AUTO && column_ready && state_q != ON
                     && !(sync_rise && state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        mux_ready_d = (state_d == ON);
        mux_out_d   = (state_d == ON) ? (SEL_ONE << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            manual_q     <= 1'b0;
            sync_q       <= 1'b0;
            mux_out_q    <= '0;
            mux_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            manual_q     <= manual_d;
            sync_q       <= sync_d;
            mux_out_q    <= mux_out_d;
            mux_ready_q  <= mux_ready_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign mux_out    = mux_out_q;
    assign mux_idx    = idx_q;
    assign mux_ready  = mux_ready_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner (NB_MUX=8, DEADTIME=4) with hand-computed expectations.
module tb_mux_scanner;

    logic       clk = 1'b0;
    logic       nrst;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] manual_sel;
    logic       column_ready;
    logic       position_sync;
    logic [7:0] mux_out;
    logic [2:0] mux_idx;
    logic       mux_ready;
    logic       frame_done;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic [7:0] prev_out = '0;
    logic [7:0] exp_out;

    always #5 clk = ~clk;

    mux_scanner #(.NB_MUX(8), .DEADTIME(4)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .enable       (enable),
        .mode         (mode),
        .manual_sel   (manual_sel),
        .column_ready (column_ready),
        .position_sync(position_sync),
        .mux_out      (mux_out),
        .mux_idx      (mux_idx),
        .mux_ready    (mux_ready),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_col();
        column_ready = 1'b1;
        tick(1);
        column_ready = 1'b0;
    endtask

    // Lines must be one-hot-or-zero and never jump directly between two selections.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot0", 32'($onehot0(mux_out)), 32'd1);
            check("no_direct_switch",
                  32'(prev_out != '0 && mux_out != '0 && mux_out != prev_out), 32'd0);
            prev_out <= mux_out;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; enable = 1'b0; mode = 2'b00; manual_sel = '0;
        column_ready = 1'b0; position_sync = 1'b0;
        tick(2);
        mon_en = 1'b1;
        check("rst_mux_out", mux_out, 0);
        check("rst_mux_idx", mux_idx, 0);
        check("rst_ready", mux_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);

        nrst = 1'b1; enable = 1'b1; mode = 2'b00;
        tick(3);
        check("off_mux_out", mux_out, 0);
        check("off_ready", mux_ready, 0);

        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("auto_start_dead", mux_out, 0);
        end
        tick(1);
        check("auto_first_on", mux_out, 8'h01);
        check("auto_first_ready", mux_ready, 1);
        check("auto_first_idx", mux_idx, 0);

        for (int k = 1; k <= 8; k++) begin
            exp_out = 8'h01 << (k % 8);
            pulse_col();
            check("sweep_frame_done", frame_done, (k == 8) ? 1 : 0);
            check("sweep_dead0", mux_out, 0);
            check("sweep_ready_low", mux_ready, 0);
            tick(3);
            check("sweep_dead3", mux_out, 0);
            tick(1);
            check("sweep_on", mux_out, exp_out);
            check("sweep_fd_clear", frame_done, 0);
            tick(15);
        end
        check("sweep_overrun", overrun, 0);

        for (int k = 1; k <= 5; k++) begin
            pulse_col();
            tick(4);
        end
        check("idx5_out", mux_out, 8'h20);
        check("idx5_idx", mux_idx, 5);
        position_sync = 1'b1;
        column_ready  = 1'b1;
        tick(1);
        column_ready  = 1'b0;
        check("sync_dead", mux_out, 0);
        check("sync_idx", mux_idx, 0);
        check("sync_fd", frame_done, 0);
        check("sync_overrun", overrun, 0);
        tick(4);
        check("sync_on", mux_out, 8'h01);
        check("sync_overrun_after", overrun, 0);
        position_sync = 1'b0;
        tick(3);

        pulse_col();
        tick(1);
        pulse_col();
        check("overrun_set", overrun, 1);
        tick(2);
        check("overrun_adv_once", mux_out, 8'h02);
        check("overrun_adv_idx", mux_idx, 1);
        tick(5);
        check("overrun_sticky", overrun, 1);
        enable = 1'b0;
        tick(1);
        check("dis_mux_out", mux_out, 0);
        check("dis_overrun", overrun, 0);
        check("dis_ready", mux_ready, 0);
        check("dis_idx_hold", mux_idx, 1);

        mode = 2'b10; manual_sel = 8'h10; enable = 1'b1;
        tick(4);
        check("man_dead", mux_out, 0);
        tick(1);
        check("man_on", mux_out, 8'h10);
        check("man_idx", mux_idx, 4);
        check("man_ready", mux_ready, 1);
        pulse_col();
        check("man_col_ignored", mux_out, 8'h10);
        check("man_no_overrun", overrun, 0);
        check("man_no_fd", frame_done, 0);
        manual_sel = 8'h11;
        tick(1);
        check("man_multihot_off", mux_out, 0);
        check("man_multihot_ready", mux_ready, 0);
        manual_sel = 8'h04;
        tick(5);
        check("man_reenter", mux_out, 8'h04);
        check("man_reenter_idx", mux_idx, 2);
        manual_sel = 8'h08;
        tick(1);
        check("man_change_dead", mux_out, 0);
        tick(4);
        check("man_change_on", mux_out, 8'h08);

        mode = 2'b01;
        tick(1);
        check("modechg_idle", mux_out, 0);
        tick(4);
        check("modechg_dead", mux_out, 0);
        tick(1);
        check("modechg_on", mux_out, 8'h01);
        check("modechg_idx", mux_idx, 0);

        pulse_col(); tick(4);
        pulse_col(); tick(4);
        pulse_col(); tick(1);
        pulse_col();
        tick(2);
        check("pre_rst_out", mux_out, 8'h08);
        check("pre_rst_overrun", overrun, 1);
        nrst = 1'b0;
        tick(1);
        check("midrst_mux_out", mux_out, 0);
        check("midrst_idx", mux_idx, 0);
        check("midrst_ready", mux_ready, 0);
        check("midrst_fd", frame_done, 0);
        check("midrst_overrun", overrun, 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
